// File: rtl/fetch_stage.sv
// Instruction fetch stage with a one-cycle-latency instruction SRAM.
//
// Each issued fetch puts nextpc on the SRAM address bus and presents it as fs_pc one cycle
// later. The SRAM data returns in that same cycle. If decode stalls then, the data is
// copied into a one-entry buffer so that it survives until decode accepts it.
// Branch delay slots work as follows. A taken branch that arrives while the stage is empty
// is parked in br_pend_q. The target is then fetched only after the sequential delay-slot
// fetch. A flush from writeback overrides everything else and drops the buffered and
// pending state.
//
// Ports:
//   clk, resetn        clock and synchronous active-low reset
//   ds_allowin         decode can accept an instruction this cycle
//   br_taken/target    taken branch/jump resolved in decode, held until ds_allowin
//   ex_flush/target    exception/ERET redirect from writeback
//   inst_sram_*        read-only instruction SRAM port (rdata one cycle after en)
//   fs_to_ds_valid     fs_pc/fs_inst/fs_adel are valid towards decode
//   fs_adel            fetch address was misaligned; fs_inst is forced to zero
module fetch_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        ex_flush,
  input  logic [31:0] ex_target,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        fs_adel
);

  // One word before the boot vector, so that the first sequential fetch lands on 0xBFC00000.
  localparam logic [31:0] ResetPc = 32'hBFBF_FFFC;

  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic        fs_adel_q, fs_adel_d;
  logic        br_pend_q, br_pend_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_inst_q, buf_inst_d;

  logic        fs_allowin;
  logic        br_redirect;
  logic        fetch;
  logic        next_adel;
  logic [31:0] nextpc;

  always_comb begin
    fs_allowin  = !fs_valid_q || ds_allowin;
    br_redirect = fs_valid_q && (br_taken || br_pend_q);

    if (ex_flush) begin
      nextpc = ex_target;
    end else if (br_redirect) begin
      nextpc = br_pend_q ? pend_target_q : br_target;
    end else begin
      nextpc = fs_pc_q + 32'd4;  // wraps naturally modulo 2^32
    end

    fetch     = resetn && (fs_allowin || ex_flush);
    next_adel = (nextpc[1:0] != 2'b00);

    inst_sram_en    = fetch && !next_adel;
    inst_sram_wen   = 4'b0000;
    inst_sram_addr  = nextpc;
    inst_sram_wdata = 32'h0;

    fs_to_ds_valid = fs_valid_q && !ex_flush;
    fs_pc          = fs_pc_q;
    fs_adel        = fs_adel_q;
    if (fs_adel_q) begin
      fs_inst = 32'h0;
    end else if (buf_valid_q) begin
      fs_inst = buf_inst_q;
    end else begin
      fs_inst = inst_sram_rdata;
    end
  end

  always_comb begin
    fs_valid_d    = fs_valid_q;
    fs_pc_d       = fs_pc_q;
    fs_adel_d     = fs_adel_q;
    buf_valid_d   = buf_valid_q;
    buf_inst_d    = buf_inst_q;
    br_pend_d     = br_pend_q;
    pend_target_d = pend_target_q;

    if (fetch) begin
      fs_valid_d  = 1'b1;
      fs_pc_d     = nextpc;
      fs_adel_d   = next_adel;
      buf_valid_d = 1'b0;
    end else if (fs_to_ds_valid && ds_allowin) begin
      fs_valid_d  = 1'b0;
      buf_valid_d = 1'b0;
    end else if (fs_valid_q && !buf_valid_q && !fs_adel_q) begin
      // Holding without a fetch means decode stalled. The SRAM data is only present in the
      // first cycle after the fetch, so it is captured then.
      buf_valid_d = 1'b1;
      buf_inst_d  = inst_sram_rdata;
    end

    if (ex_flush) begin
      br_pend_d = 1'b0;
    end else if (br_pend_q && fs_valid_q && fetch) begin
      br_pend_d = 1'b0;
    end else if (br_taken && ds_allowin && !fs_valid_q) begin
      // The delay slot has not been fetched yet, so the target is deferred by one fetch.
      br_pend_d     = 1'b1;
      pend_target_d = br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fs_valid_q    <= 1'b0;
      fs_pc_q       <= ResetPc;
      fs_adel_q     <= 1'b0;
      buf_valid_q   <= 1'b0;
      buf_inst_q    <= 32'h0;
      br_pend_q     <= 1'b0;
      pend_target_q <= 32'h0;
    end else begin
      fs_valid_q    <= fs_valid_d;
      fs_pc_q       <= fs_pc_d;
      fs_adel_q     <= fs_adel_d;
      buf_valid_q   <= buf_valid_d;
      buf_inst_q    <= buf_inst_d;
      br_pend_q     <= br_pend_d;
      pend_target_q <= pend_target_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Each table row is one clock cycle of inputs. The row also
// carries the fetch address and the decode handoff expected in that cycle. The expectations
// go into queues, and independent monitors pop them whenever the DUT fetches or hands off.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        resetn, ds_allowin, br_taken, ex_flush;
  logic [31:0] br_target, ex_target;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic        fs_to_ds_valid, fs_adel;
  logic [31:0] fs_pc, fs_inst;

  int checks = 0;
  int failures = 0;

  fetch_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ds_allowin      (ds_allowin),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .ex_flush        (ex_flush),
    .ex_target       (ex_target),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_pc           (fs_pc),
    .fs_inst         (fs_inst),
    .fs_adel         (fs_adel)
  );

  always #5 clk = ~clk;

  // Instruction memory contents; 0xBFC00004 holds the instruction named in the stall test.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hBFC0_0004) return 32'h2401_0001;
    return a ^ 32'h1357_9BDF;
  endfunction

  // Read data is valid only in the cycle after en; it reads as garbage at all other times.
  always @(posedge clk) begin
    inst_sram_rdata <= inst_sram_en ? mem_word(inst_sram_addr) : 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rstn, ds, brt;
    logic [31:0] brtgt;
    logic        exf;
    logic [31:0] extgt;
    logic        a_v;
    logic [31:0] a;
    logic        h_v;
    logic [31:0] h_pc;
    logic        h_adel;
  } row_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } ho_t;

  logic [31:0] exp_addr_q[$];
  ho_t         exp_ho_q[$];

  localparam int NRows = 28;
  row_t rows [NRows];

  initial begin
    // rstn ds brt brtgt          exf extgt          a_v addr           h_v h_pc          adel
    rows[0]  = '{1, 1, 0, 32'h0,          0, 32'h0,          1, 32'hBFC00000, 0, 32'h0,          0};
    rows[1]  = '{1, 1, 0, 32'h0,          0, 32'h0,          1, 32'hBFC00004, 1, 32'hBFC00000, 0};
    rows[2]  = '{1, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h0,          0};
    rows[3]  = '{1, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h0,          0};
    rows[4]  = '{1, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h0,          0};
    rows[5]  = '{1, 1, 0, 32'h0,          0, 32'h0,          1, 32'hBFC00008, 1, 32'hBFC00004, 0};
    rows[6]  = '{1, 1, 1, 32'hBFC00100, 0, 32'h0,          1, 32'hBFC00100, 1, 32'hBFC00008, 0};
    rows[7]  = '{1, 1, 0, 32'h0,          0, 32'h0,          1, 32'hBFC00104, 1, 32'hBFC00100, 0};
    rows[8]  = '{1, 1, 1, 32'hBFC00200, 1, 32'hBFC00380, 1, 32'hBFC00380, 0, 32'h0,          0};
    rows[9]  = '{1, 1, 0, 32'h0,          0, 32'h0,          1, 32'hBFC00384, 1, 32'hBFC00380, 0};
    rows[10] = '{1, 1, 1, 32'hBFC00102, 0, 32'h0,          0, 32'h0,          1, 32'hBFC00384, 0};
    rows[11] = '{1, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 32'hBFC00102, 1};
    rows[12] = '{1, 1, 0, 32'h0,          1, 32'hBFC00380, 1, 32'hBFC00380, 0, 32'h0,          0};
    rows[13] = '{0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h0,          0};
    rows[14] = '{0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h0,          0};
    rows[15] = '{1, 1, 1, 32'hBFC00100, 0, 32'h0,          1, 32'hBFC00000, 0, 32'h0,          0};
    rows[16] = '{1, 1, 0, 32'h0,          0, 32'h0,          1, 32'hBFC00100, 1, 32'hBFC00000, 0};
    rows[17] = '{1, 1, 0, 32'h0,          0, 32'h0,          1, 32'hBFC00104, 1, 32'hBFC00100, 0};
    rows[18] = '{0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h0,          0};
    rows[19] = '{1, 1, 1, 32'hBFC00100, 0, 32'h0,          1, 32'hBFC00000, 0, 32'h0,          0};
    rows[20] = '{0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h0,          0};
    rows[21] = '{1, 1, 0, 32'h0,          0, 32'h0,          1, 32'hBFC00000, 0, 32'h0,          0};
    rows[22] = '{1, 1, 0, 32'h0,          0, 32'h0,          1, 32'hBFC00004, 1, 32'hBFC00000, 0};
    rows[23] = '{1, 1, 0, 32'h0,          1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 32'h0,          0};
    rows[24] = '{1, 1, 0, 32'h0,          0, 32'h0,          1, 32'h00000000, 1, 32'hFFFFFFFC, 0};
    rows[25] = '{1, 1, 0, 32'h0,          0, 32'h0,          1, 32'h00000004, 1, 32'h00000000, 0};
    rows[26] = '{1, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h0,          0};
    rows[27] = '{1, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h0,          0};
  end

  // Fetch-request monitor.
  always @(negedge clk) begin
    if (inst_sram_en === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_fetch: got addr %h expected no fetch (t=%0t)",
                 inst_sram_addr, $time);
      end else begin
        check("fetch_addr", inst_sram_addr, exp_addr_q.pop_front());
      end
    end
  end

  // Decode handoff monitor.
  always @(negedge clk) begin
    if (fs_to_ds_valid === 1'b1 && ds_allowin === 1'b1) begin
      if (exp_ho_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_handoff: got pc %h expected no handoff (t=%0t)", fs_pc, $time);
      end else begin
        ho_t e;
        e = exp_ho_q.pop_front();
        check("ho_pc", fs_pc, e.pc);
        check("ho_inst", fs_inst, e.inst);
        check("ho_adel", {31'h0, fs_adel}, {31'h0, e.adel});
      end
    end
  end

  initial begin
    resetn = 1'b0; ds_allowin = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    ex_flush = 1'b0; ex_target = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_en", {31'h0, inst_sram_en}, 32'h0);
    check("rst_valid", {31'h0, fs_to_ds_valid}, 32'h0);
    check("rst_pc", fs_pc, 32'hBFBF_FFFC);
    check("rst_adel", {31'h0, fs_adel}, 32'h0);

    for (int i = 0; i < NRows; i++) begin
      @(posedge clk);
      #1;
      resetn     = rows[i].rstn;
      ds_allowin = rows[i].ds;
      br_taken   = rows[i].brt;
      br_target  = rows[i].brtgt;
      ex_flush   = rows[i].exf;
      ex_target  = rows[i].extgt;
      if (rows[i].a_v) exp_addr_q.push_back(rows[i].a);
      if (rows[i].h_v) begin
        ho_t h;
        h.pc   = rows[i].h_pc;
        h.inst = rows[i].h_adel ? 32'h0 : mem_word(rows[i].h_pc);
        h.adel = rows[i].h_adel;
        exp_ho_q.push_back(h);
      end
      @(negedge clk);
      check($sformatf("en_row%0d", i), {31'h0, inst_sram_en}, {31'h0, rows[i].a_v});
      check("wen", {28'h0, inst_sram_wen}, 32'h0);
      check("wdata", inst_sram_wdata, 32'h0);
      if (i >= 2 && i <= 4) begin
        check("stall_inst", fs_inst, 32'h2401_0001);
        check("stall_pc", fs_pc, 32'hBFC0_0004);
      end
      if (i == 8 || i == 12) check("flush_valid", {31'h0, fs_to_ds_valid}, 32'h0);
      if (i == 10) check("adel_addr", inst_sram_addr, 32'hBFC0_0102);
      if (i == 11) begin
        check("adel_flag", {31'h0, fs_adel}, 32'h1);
        check("adel_inst", fs_inst, 32'h0);
      end
      if (i == 14) begin
        check("midrst_pc", fs_pc, 32'hBFBF_FFFC);
        check("midrst_valid", {31'h0, fs_to_ds_valid}, 32'h0);
      end
      if (i == 27) check("tail_hold_pc", fs_pc, 32'h0000_0004);
    end

    check("addr_q_empty", exp_addr_q.size(), 32'h0);
    check("ho_q_empty", exp_ho_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: resetn  input  1  synchronous, active-low reset.
REQ-003 SHALL have port: ds_allowin  input  1  decode stage can accept an instruction this cycle.
REQ-004 SHALL have port: br_taken  input  1  decode resolved a taken branch/jump; held high until ds_allowin.
REQ-005 SHALL have port: br_target  input  32  branch/jump target; valid with br_taken.
REQ-006 SHALL have port: ex_flush  input  1  exception/ERET flush from writeback.
REQ-007 SHALL have port: ex_target  input  32  flush target (0xBFC00380 or EPC).
REQ-008 SHALL have ports: inst_sram_en out 1; inst_sram_wen out 4; inst_sram_addr out 32; inst_sram_wdata out 32; inst_sram_rdata in 32 (rdata valid exactly 1 cycle after en).
REQ-009 SHALL have ports: fs_to_ds_valid out 1; fs_pc out 32; fs_inst out 32; fs_adel out 1 (fetch address error).

Function
REQ-010 fs_allowin SHALL be !fs_valid || ds_allowin; fs_to_ds_valid SHALL be fs_valid && !ex_flush.
REQ-011 nextpc priority SHALL be: ex_flush -> ex_target; else (fs_valid && (br_taken || br_pending)) -> br_pending ? pend_target : br_target; else fs_pc+4.
REQ-012 A fetch SHALL be issued in any cycle with resetn=1 and (fs_allowin || ex_flush): inst_sram_addr=nextpc, inst_sram_en=1 unless nextpc[1:0]!=0.
REQ-013 inst_sram_wen SHALL be 4'b0000 and inst_sram_wdata 32'h0 always.
REQ-014 On an issued fetch, next cycle fs_valid=1, fs_pc=nextpc, fs_adel=(nextpc[1:0]!=0).
REQ-015 When fs_adel=1, fs_inst SHALL be 32'h0 and no SRAM access SHALL occur for that PC.
REQ-016 fs_inst SHALL be inst_sram_rdata in the cycle after the fetch; if ds_allowin=0 that cycle, rdata SHALL be captured into an instruction buffer and fs_inst driven from it until fs_valid drops or is reloaded.
REQ-017 fs_valid SHALL clear when fs_to_ds_valid && ds_allowin and no new fetch is issued.
REQ-018 Delay slot: if br_taken && ds_allowin && !fs_valid, br_pending SHALL set and pend_target=br_target; the concurrent fetch SHALL be fs_pc+4 (delay slot).
REQ-019 br_pending SHALL clear when a fetch using pend_target is issued, or on ex_flush.
REQ-020 br_taken with fs_valid=1 and fs_allowin=1 SHALL fetch br_target directly; br_pending unchanged (0).
REQ-021 ex_flush SHALL override a concurrent br_taken/br_pending; next cycle fs_pc=ex_target, buffer invalidated, stale rdata discarded.
REQ-022 fs_pc+4 SHALL wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-023 With fs_allowin=0 and no ex_flush, inst_sram_en SHALL be 0 and fs_pc, fs_inst, fs_adel SHALL hold.

Reset
REQ-024 While resetn=0 at a clock edge: fs_valid=0, br_pending=0, buffer invalid, fs_pc=32'hBFBFFFFC, fs_adel=0; inst_sram_en=0 combinationally while resetn=0.
REQ-025 First cycle with resetn=1 SHALL issue fetch to 32'hBFC00000.
REQ-026 Reset asserted mid-stall or mid-branch SHALL discard buffer and pending branch with no SRAM request.

Verification
REQ-027 Reset release, ds_allowin=1 -> addr 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive cycles; fs_pc follows one cycle later.
REQ-028 ds_allowin=0 for 3 cycles after fetch of 0xBFC00004 returning 0x24010001 -> en=0, fs_inst holds 0x24010001 throughout, released next fetch addr 0xBFC00008.
REQ-029 br_taken=1, br_target=0xBFC00100 with delay slot 0xBFC00008 in fs -> next addr 0xBFC00100; fs_pc sequence ...0x08, 0x100.
REQ-030 br_taken while fs_valid=0 -> fetch pc+4 (delay slot) first, then 0xBFC00100; br_pending 1 for exactly those cycles.
REQ-031 ex_flush=1, ex_target=0xBFC00380 same cycle as br_taken -> addr 0xBFC00380, fs_to_ds_valid=0 that cycle, br_pending=0 afterwards.
REQ-032 br_target=0xBFC00102 -> en=0 for that PC, fs_adel=1, fs_pc=0xBFC00102, fs_inst=0.
